// File: rtl/writeback_stage_pipe_if.sv
// MEM/WB boundary bundle: payload from the memory stage into the writeback
// stage, and the regfile write / forwarding / retire outputs back out.
interface writeback_stage_pipe_if #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int RETIRE_W = 32
);
    localparam int SEL_W = $clog2(NUM_SRC);

    // Pipeline control and incoming payload
    logic                    i_wb_stall;
    logic                    i_wb_flush;
    logic                    i_wb_valid;
    logic [31:0]             i_wb_inst;
    logic [NUM_SRC*XLEN-1:0] i_wb_src_data;
    logic [SEL_W-1:0]        i_wb_wb_sel;
    logic                    i_wb_rd_wren;
    logic [1:0]              i_wb_ld_off;

    // Registered results
    logic [XLEN-1:0]         o_wb_data_wb;
    logic [4:0]              o_wb_rd_addr;
    logic                    o_wb_rd_wren;
    logic                    o_wb_fwd_valid;
    logic [4:0]              o_wb_fwd_addr;
    logic [XLEN-1:0]         o_wb_fwd_data;
    logic                    o_wb_valid;
    logic [RETIRE_W-1:0]     o_wb_retire_cnt;

    // Upstream side: drives the payload, observes the stage outputs
    modport master (
        output i_wb_stall, i_wb_flush, i_wb_valid, i_wb_inst, i_wb_src_data,
               i_wb_wb_sel, i_wb_rd_wren, i_wb_ld_off,
        input  o_wb_data_wb, o_wb_rd_addr, o_wb_rd_wren, o_wb_fwd_valid,
               o_wb_fwd_addr, o_wb_fwd_data, o_wb_valid, o_wb_retire_cnt
    );

    // The writeback stage itself
    modport slave (
        input  i_wb_stall, i_wb_flush, i_wb_valid, i_wb_inst, i_wb_src_data,
               i_wb_wb_sel, i_wb_rd_wren, i_wb_ld_off,
        output o_wb_data_wb, o_wb_rd_addr, o_wb_rd_wren, o_wb_fwd_valid,
               o_wb_fwd_addr, o_wb_fwd_data, o_wb_valid, o_wb_retire_cnt
    );
endinterface

// File: rtl/writeback_stage_pipe.sv
// RV32 writeback stage: selects the result source, aligns/extends load data,
// registers the MEM/WB payload under stall/flush control, drives the regfile
// write port and forwarding bus, and counts retired instructions.
module writeback_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int RETIRE_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    writeback_stage_pipe_if.slave wb
);
    localparam int SEL_W = $clog2(NUM_SRC);

    // Load funct3 encodings handled by the aligner
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    // Decoded inputs
    logic [SEL_W-1:0] sel;
    logic [2:0]       funct3;
    logic [4:0]       rd_field;
    logic [1:0]       ld_off;
    logic [XLEN-1:0]  src0;
    logic [31:0]      ld_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    // Combinational results ahead of the pipeline register
    logic [XLEN-1:0]  src_sel_data;
    logic [XLEN-1:0]  ld_aligned;
    logic [XLEN-1:0]  wb_data_next;

    // Pipeline register state and next-state
    logic                valid_q, valid_d;
    logic                wren_q, wren_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;

    // Opcode and upper instruction bits carry no meaning at this stage
    logic unused_inst_bits;
    assign unused_inst_bits = ^{wb.i_wb_inst[31:15], wb.i_wb_inst[6:0]};

    assign sel      = wb.i_wb_wb_sel;
    assign funct3   = wb.i_wb_inst[14:12];
    assign rd_field = wb.i_wb_inst[11:7];
    assign ld_off   = wb.i_wb_ld_off;
    assign src0     = wb.i_wb_src_data[XLEN-1:0];
    assign ld_word  = src0[31:0];

    // Byte lane picked by the full offset; halfword lane by offset[1] only,
    // so a misaligned LH quietly reads the enclosing aligned half.
    assign ld_byte  = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_half  = ld_word[{ld_off[1], 4'b0000} +: 16];

    // Pick the result source; selects beyond NUM_SRC yield zero
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        src_sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(sel) == k) begin
                src_sel_data = wb.i_wb_src_data[k*XLEN +: XLEN];
            end
        end
    end

    // Align and extend load data from source 0 according to funct3
    always_comb begin
        ld_aligned = src0;
        case (funct3)
            F3_LB:   ld_aligned = XLEN'($signed(ld_byte));
            F3_LH:   ld_aligned = XLEN'($signed(ld_half));
            F3_LW:   ld_aligned = XLEN'($signed(ld_word));
            F3_LBU:  ld_aligned = XLEN'(ld_byte);
            F3_LHU:  ld_aligned = XLEN'(ld_half);
            default: ld_aligned = src0;
        endcase
    end

    // Alignment only matters for the load source
    assign wb_data_next = (sel == '0) ? ld_aligned : src_sel_data;

    // Next-state: flush squashes, stall holds everything, otherwise load
    always_comb begin
        valid_d      = valid_q;
        wren_d       = wren_q;
        rd_d         = rd_q;
        data_d       = data_q;
        retire_cnt_d = retire_cnt_q;
        if (wb.i_wb_flush) begin
            // Data and rd are left as-is; valid=0 already blocks any write
            valid_d = 1'b0;
            wren_d  = 1'b0;
        end else if (!wb.i_wb_stall) begin
            valid_d = wb.i_wb_valid;
            wren_d  = wb.i_wb_rd_wren;
            rd_d    = rd_field;
            data_d  = wb_data_next;
            if (wb.i_wb_valid) begin
                // Every real instruction retires, with or without an rd write
                retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
            end
        end
    end

    // Pipeline register with synchronous reset taking priority
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (i_reset) begin
            // NOTE: the datapath registers are reset too, not just the
            // control bits, because all outputs must read zero after reset.
            valid_q      <= 1'b0;
            wren_q       <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            wren_q       <= wren_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Regfile write, suppressed for x0 and for bubbles
    assign wb.o_wb_rd_wren    = valid_q & wren_q & (rd_q != 5'd0);
    assign wb.o_wb_data_wb    = data_q;
    assign wb.o_wb_rd_addr    = rd_q;
    assign wb.o_wb_valid      = valid_q;

    // Forwarding bus mirrors the regfile write port
    assign wb.o_wb_fwd_valid  = wb.o_wb_rd_wren;
    assign wb.o_wb_fwd_addr   = rd_q;
    assign wb.o_wb_fwd_data   = data_q;

    assign wb.o_wb_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Directed bench for writeback_stage_pipe: default build (4 sources, 32-bit
// counter) plus a 3-source / 4-bit-counter build for range and wrap cases.
module tb_writeback_stage_pipe;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_X   = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    writeback_stage_pipe_if #(.XLEN(32), .NUM_SRC(4), .RETIRE_W(32)) if_a ();
    writeback_stage_pipe_if #(.XLEN(32), .NUM_SRC(3), .RETIRE_W(4))  if_b ();

    writeback_stage_pipe #(.XLEN(32), .NUM_SRC(4), .RETIRE_W(32)) dut_a (
        .i_clk   (clk),
        .i_reset (rst_a),
        .wb      (if_a)
    );

    writeback_stage_pipe #(.XLEN(32), .NUM_SRC(3), .RETIRE_W(4)) dut_b (
        .i_clk   (clk),
        .i_reset (rst_b),
        .wb      (if_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic valid, input logic [1:0] sel, input logic [4:0] rd,
                           input logic [2:0] f3, input logic wren, input logic [1:0] off);
        if_a.i_wb_valid   = valid;
        if_a.i_wb_wb_sel  = sel;
        if_a.i_wb_inst    = {17'h0, f3, rd, 7'b0000011};
        if_a.i_wb_rd_wren = wren;
        if_a.i_wb_ld_off  = off;
    endtask

    task automatic drive_b(input logic valid, input logic [1:0] sel, input logic [4:0] rd);
        if_b.i_wb_valid   = valid;
        if_b.i_wb_wb_sel  = sel;
        if_b.i_wb_inst    = {17'h0, F3_LW, rd, 7'b0110011};
        if_b.i_wb_rd_wren = 1'b1;
        if_b.i_wb_ld_off  = 2'd0;
    endtask

    // Full output check of the default build
    task automatic check_a(input string tag, input logic [31:0] data, input logic [4:0] rd,
                           input logic wr, input logic valid, input logic [31:0] cnt);
        check({tag, ".data"},     if_a.o_wb_data_wb,    data);
        check({tag, ".rd"},       if_a.o_wb_rd_addr,    rd);
        check({tag, ".wren"},     if_a.o_wb_rd_wren,    wr);
        check({tag, ".valid"},    if_a.o_wb_valid,      valid);
        check({tag, ".fwd_v"},    if_a.o_wb_fwd_valid,  wr);
        check({tag, ".fwd_a"},    if_a.o_wb_fwd_addr,   rd);
        check({tag, ".fwd_d"},    if_a.o_wb_fwd_data,   data);
        check({tag, ".cnt"},      if_a.o_wb_retire_cnt, cnt);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.i_wb_stall    = 1'b0;
        if_a.i_wb_flush    = 1'b0;
        if_a.i_wb_src_data = '0;
        drive_a(1'b0, 2'd0, 5'd0, F3_LB, 1'b0, 2'd0);
        if_b.i_wb_stall    = 1'b0;
        if_b.i_wb_flush    = 1'b0;
        if_b.i_wb_src_data = '0;
        drive_b(1'b0, 2'd0, 5'd0);

        // Reset state
        tick();
        tick();
        check_a("reset", 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);

        // ALU result through source 1
        rst_a = 1'b0;
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h1234_5678, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd5, F3_LB, 1'b1, 2'd0);
        tick();
        check_a("alu", 32'h1234_5678, 5'd5, 1'b1, 1'b1, 32'd1);

        // Load alignment on source 0 = 0x80FF_7F01
        drive_a(1'b1, 2'd0, 5'd10, F3_LB, 1'b1, 2'd1);  tick();
        check_a("lb_off1", 32'h0000_007F, 5'd10, 1'b1, 1'b1, 32'd2);
        drive_a(1'b1, 2'd0, 5'd10, F3_LB, 1'b1, 2'd2);  tick();
        check_a("lb_off2", 32'hFFFF_FFFF, 5'd10, 1'b1, 1'b1, 32'd3);
        drive_a(1'b1, 2'd0, 5'd11, F3_LBU, 1'b1, 2'd3); tick();
        check_a("lbu_off3", 32'h0000_0080, 5'd11, 1'b1, 1'b1, 32'd4);
        drive_a(1'b1, 2'd0, 5'd12, F3_LH, 1'b1, 2'd2);  tick();
        check_a("lh_off2", 32'hFFFF_80FF, 5'd12, 1'b1, 1'b1, 32'd5);
        drive_a(1'b1, 2'd0, 5'd13, F3_LHU, 1'b1, 2'd0); tick();
        check_a("lhu_off0", 32'h0000_7F01, 5'd13, 1'b1, 1'b1, 32'd6);
        drive_a(1'b1, 2'd0, 5'd14, F3_LW, 1'b1, 2'd3);  tick();
        check_a("lw_off3", 32'h80FF_7F01, 5'd14, 1'b1, 1'b1, 32'd7);
        drive_a(1'b1, 2'd0, 5'd15, F3_X, 1'b1, 2'd2);   tick();
        check_a("f3_other", 32'h80FF_7F01, 5'd15, 1'b1, 1'b1, 32'd8);
        drive_a(1'b1, 2'd0, 5'd16, F3_LH, 1'b1, 2'd3);  tick();
        check_a("lh_off3", 32'hFFFF_80FF, 5'd16, 1'b1, 1'b1, 32'd9);
        drive_a(1'b1, 2'd0, 5'd17, F3_LH, 1'b1, 2'd1);  tick();
        check_a("lh_off1", 32'h0000_7F01, 5'd17, 1'b1, 1'b1, 32'd10);

        // Sources 2 and 3, and no alignment on a non-load source
        drive_a(1'b1, 2'd2, 5'd3, F3_LB, 1'b1, 2'd1);   tick();
        check_a("src2", 32'hAAAA_0004, 5'd3, 1'b1, 1'b1, 32'd11);
        drive_a(1'b1, 2'd3, 5'd4, F3_LB, 1'b1, 2'd1);   tick();
        check_a("src3", 32'hC5C5_0000, 5'd4, 1'b1, 1'b1, 32'd12);
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'hDEAD_BEEF, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd6, F3_LB, 1'b1, 2'd3);   tick();
        check_a("src1_noalign", 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b1, 32'd13);

        // x0 write suppressed but still retires
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h0000_0BAD, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd0, F3_LW, 1'b1, 2'd0);   tick();
        check_a("x0", 32'h0000_0BAD, 5'd0, 1'b0, 1'b1, 32'd14);

        // Bubble: no write, no retire
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h0000_0044, 32'h80FF_7F01};
        drive_a(1'b0, 2'd1, 5'd4, F3_LW, 1'b1, 2'd0);   tick();
        check_a("bubble", 32'h0000_0044, 5'd4, 1'b0, 1'b0, 32'd14);

        // Load rd=7 then stall three cycles with new inputs waiting
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h0000_0077, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd7, F3_LW, 1'b1, 2'd0);   tick();
        check_a("rd7", 32'h0000_0077, 5'd7, 1'b1, 1'b1, 32'd15);
        if_a.i_wb_stall    = 1'b1;
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h0000_0099, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd9, F3_LW, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a($sformatf("stall%0d", i), 32'h0000_0077, 5'd7, 1'b1, 1'b1, 32'd15);
        end

        // Flush together with stall: flush wins, counter holds
        if_a.i_wb_flush = 1'b1;
        tick();
        check("flush_stall.valid", if_a.o_wb_valid, 1'b0);
        check("flush_stall.wren",  if_a.o_wb_rd_wren, 1'b0);
        check("flush_stall.fwd_v", if_a.o_wb_fwd_valid, 1'b0);
        check("flush_stall.cnt",   if_a.o_wb_retire_cnt, 32'd15);

        // Resume, then a plain flush
        if_a.i_wb_flush    = 1'b0;
        if_a.i_wb_stall    = 1'b0;
        if_a.i_wb_src_data = {32'hC5C5_0000, 32'hAAAA_0004, 32'h0000_0088, 32'h80FF_7F01};
        drive_a(1'b1, 2'd1, 5'd8, F3_LW, 1'b1, 2'd0);   tick();
        check_a("resume", 32'h0000_0088, 5'd8, 1'b1, 1'b1, 32'd16);
        if_a.i_wb_flush = 1'b1;
        tick();
        check("flush.valid", if_a.o_wb_valid, 1'b0);
        check("flush.wren",  if_a.o_wb_rd_wren, 1'b0);
        check("flush.cnt",   if_a.o_wb_retire_cnt, 32'd16);

        // Reset mid-stream while stalled with a valid payload
        if_a.i_wb_flush = 1'b0;
        drive_a(1'b1, 2'd1, 5'd8, F3_LW, 1'b1, 2'd0);   tick();
        check("pre_rst.cnt", if_a.o_wb_retire_cnt, 32'd17);
        if_a.i_wb_stall = 1'b1;
        rst_a = 1'b1;
        tick();
        check_a("mid_reset", 32'h0, 5'd0, 1'b0, 1'b0, 32'd0);
        rst_a = 1'b0;
        if_a.i_wb_stall = 1'b0;
        drive_a(1'b0, 2'd0, 5'd0, F3_LB, 1'b0, 2'd0);

        // Three-source build: select 3 is out of range and reads zero
        rst_b = 1'b0;
        if_b.i_wb_src_data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        drive_b(1'b1, 2'd3, 5'd6);
        tick();
        check("b_sel3.data", if_b.o_wb_data_wb, 32'h0);
        check("b_sel3.wren", if_b.o_wb_rd_wren, 1'b1);
        check("b_sel3.cnt",  if_b.o_wb_retire_cnt, 4'd1);
        drive_b(1'b1, 2'd2, 5'd6);
        tick();
        check("b_sel2.data", if_b.o_wb_data_wb, 32'hCCCC_0002);

        // Wrap: 16 retired so far leaves 0, the 17th gives 1
        drive_b(1'b1, 2'd1, 5'd2);
        for (int i = 0; i < 14; i++) tick();
        check("b_wrap16.cnt", if_b.o_wb_retire_cnt, 4'd0);
        tick();
        check("b_wrap17.cnt", if_b.o_wb_retire_cnt, 4'd1);
        check("b_wrap17.data", if_b.o_wb_data_wb, 32'hBBBB_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
